// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and requester identifiers for the register-file write arbiter.
// Optional RAW hazard detection is enabled with the REGFILE_ARB_HAZARD_EN macro.
package regfile_arb_pkg;
  localparam int REG_ADDR_W      = 3;
  localparam int REG_DATA_W      = 16;
  localparam int DEFAULT_NUM_REQ = 3;

  typedef enum logic [1:0] {
    REQ_ALU  = 2'd0,
    REQ_MEM  = 2'd1,
    REQ_LINK = 2'd2
  } req_id_e;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches upward from a rotating pointer for the first valid requester.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               hold,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    if (!hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
        if (!found && valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          index       = cand;
        end
      end
    end
  end

  // The requester just served drops to lowest priority on the next search.
  always_comb next_ptr = IDX_W'((int'(index) + 1) % NUM_REQ);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= next_ptr;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ valid/ready writeback sources.
// Define REGFILE_ARB_HAZARD_EN to add read-address ports and the RAW hazard flag.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       input_hold,
  input  logic [NUM_REQ-1:0]         input_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  input_req_address,
  input  logic [NUM_REQ*DATA_W-1:0]  input_req_value,
  output logic [NUM_REQ-1:0]         output_req_ready,
  output logic                       output_reg_write,
  output logic [ADDR_W-1:0]          output_reg_write_address,
  output logic [DATA_W-1:0]          output_reg_write_value,
  output logic [$clog2(NUM_REQ)-1:0] output_grant_id
`ifdef REGFILE_ARB_HAZARD_EN
  ,
  input  logic [ADDR_W-1:0]          input_reg_readA_address,
  input  logic [ADDR_W-1:0]          input_reg_readB_address,
  output logic                       output_raw_hazard
`endif
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] grant_p0;
  logic [IDX_W-1:0]   index_p0;
  logic               transfer_p0;
  logic [ADDR_W-1:0]  address_p0;
  logic [DATA_W-1:0]  value_p0;

  logic               write_p1;
  logic [ADDR_W-1:0]  address_p1;
  logic [DATA_W-1:0]  value_p1;
  logic [IDX_W-1:0]   id_p1;

  // Stage p0: combinational grant and selection of the winner's payload.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (CLK),
    .rst_n   (RST_N),
    .valid   (input_req_valid),
    .hold    (input_hold | ~RST_N),
    .advance (transfer_p0),
    .grant   (grant_p0),
    .index   (index_p0)
  );

  assign output_req_ready = grant_p0;
  assign transfer_p0      = |(input_req_valid & grant_p0);

  always_comb begin
    address_p0 = input_req_address[int'(index_p0)*ADDR_W +: ADDR_W];
    value_p0   = input_req_value[int'(index_p0)*DATA_W +: DATA_W];
  end

  // Stage p1: registered write port; payload holds when no transfer occurs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      write_p1   <= 1'b0;
      address_p1 <= '0;
      value_p1   <= '0;
      id_p1      <= '0;
    end else begin
      write_p1 <= transfer_p0;
      if (transfer_p0) begin
        address_p1 <= address_p0;
        value_p1   <= value_p0;
        id_p1      <= index_p0;
      end
    end
  end

  assign output_reg_write         = write_p1;
  assign output_reg_write_address = address_p1;
  assign output_reg_write_value   = value_p1;
  assign output_grant_id          = id_p1;

`ifdef REGFILE_ARB_HAZARD_EN
  // A read of the register being written this cycle would see the old value.
  assign output_raw_hazard = write_p1 &&
                             ((address_p1 == input_reg_readA_address) ||
                              (address_p1 == input_reg_readB_address));
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a reference arbiter model queues expected writes.
module tb_regfile_write_arbiter;
  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int IDX_W   = $clog2(NUM_REQ);

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    logic [IDX_W-1:0]  id;
  } wr_t;

  logic                      CLK = 1'b0;
  logic                      RST_N;
  logic                      input_hold;
  logic [NUM_REQ-1:0]        input_req_valid;
  logic [NUM_REQ*ADDR_W-1:0] input_req_address;
  logic [NUM_REQ*DATA_W-1:0] input_req_value;
  logic [NUM_REQ-1:0]        output_req_ready;
  logic                      output_reg_write;
  logic [ADDR_W-1:0]         output_reg_write_address;
  logic [DATA_W-1:0]         output_reg_write_value;
  logic [IDX_W-1:0]          output_grant_id;
`ifdef REGFILE_ARB_HAZARD_EN
  logic [ADDR_W-1:0]         input_reg_readA_address;
  logic [ADDR_W-1:0]         input_reg_readB_address;
  logic                      output_raw_hazard;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  wr_t         exp_q[$];
  int          m_ptr = 0;
  int          last_grant = -1;
  logic [DATA_W-1:0] rf [0:(1<<ADDR_W)-1];

  always #5 CLK = ~CLK;

  regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK                      (CLK),
    .RST_N                    (RST_N),
    .input_hold               (input_hold),
    .input_req_valid          (input_req_valid),
    .input_req_address        (input_req_address),
    .input_req_value          (input_req_value),
    .output_req_ready         (output_req_ready),
    .output_reg_write         (output_reg_write),
    .output_reg_write_address (output_reg_write_address),
    .output_reg_write_value   (output_reg_write_value),
    .output_grant_id          (output_grant_id)
`ifdef REGFILE_ARB_HAZARD_EN
    ,
    .input_reg_readA_address  (input_reg_readA_address),
    .input_reg_readB_address  (input_reg_readB_address),
    .output_raw_hazard        (output_raw_hazard)
`endif
  );

  // Downstream register file, written by the arbiter's write port.
  always @(posedge CLK) begin
    if (output_reg_write) rf[output_reg_write_address] <= output_reg_write_value;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    input_req_valid[i]                  = v;
    input_req_address[i*ADDR_W +: ADDR_W] = a;
    input_req_value[i*DATA_W +: DATA_W]   = d;
  endtask

  // One clock: check registered outputs and ready at the falling edge, then advance.
  task automatic tick();
    logic [NUM_REQ-1:0] eg;
    wr_t  e;
    logic has_w;
    int   k;
    @(negedge CLK);
    has_w = 1'b0;
    e     = '0;
    if (exp_q.size() > 0) begin
      e     = exp_q.pop_front();
      has_w = 1'b1;
      check_val("write", 32'(output_reg_write), 32'd1);
      check_val("address", 32'(output_reg_write_address), 32'(e.a));
      check_val("value", 32'(output_reg_write_value), 32'(e.v));
      check_val("grant_id", 32'(output_grant_id), 32'(e.id));
    end else begin
      check_val("write_idle", 32'(output_reg_write), 32'd0);
    end
`ifdef REGFILE_ARB_HAZARD_EN
    check_val("raw_hazard", 32'(output_raw_hazard),
              32'(has_w && (e.a == input_reg_readA_address || e.a == input_reg_readB_address)));
`endif
    eg = '0;
    last_grant = -1;
    if (RST_N && !input_hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        k = (m_ptr + i) % NUM_REQ;
        if (last_grant < 0 && input_req_valid[k]) begin
          last_grant = k;
          eg[k] = 1'b1;
        end
      end
    end
    check_val("ready", 32'(output_req_ready), 32'(eg));
    if (!RST_N) begin
      m_ptr = 0;
    end else if (last_grant >= 0) begin
      exp_q.push_back('{a: input_req_address[last_grant*ADDR_W +: ADDR_W],
                        v: input_req_value[last_grant*DATA_W +: DATA_W],
                        id: IDX_W'(last_grant)});
      m_ptr = (last_grant + 1) % NUM_REQ;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0;
    input_hold = 1'b0;
    input_req_valid = '0;
    input_req_address = '0;
    input_req_value = '0;
`ifdef REGFILE_ARB_HAZARD_EN
    input_reg_readA_address = '0;
    input_reg_readB_address = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, ADDR_W'(i + 1), DATA_W'(16'hA000 + i));

    // Reset with every requester valid, then round-robin over six cycles.
    tick();
    tick();
    RST_N = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    input_req_valid = '0;
    tick();

    // Single write from requester 1.
    set_req(1, 1'b1, 3'd5, 16'hBEEF);
    tick();
    input_req_valid = '0;
    tick();

    // Collision on r3 with the pointer at 2: requester 2 wins first.
    set_req(0, 1'b1, 3'd3, 16'h1111);
    set_req(2, 1'b1, 3'd3, 16'h2222);
    tick();
    input_req_valid[2] = 1'b0;
    tick();
    input_req_valid = '0;
    tick();
    check_val("rf_r3", 32'(rf[3]), 32'h1111);

    // Hold blocks grants; the grant follows release.
    input_hold = 1'b1;
    set_req(0, 1'b1, 3'd6, 16'h0606);
    tick();
    tick();
    input_hold = 1'b0;
    tick();
    input_req_valid = '0;
    tick();

    // Reset the cycle after a grant; afterwards requester 0 is served first.
    set_req(1, 1'b1, 3'd7, 16'h7777);
    tick();
    input_req_valid = '0;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, ADDR_W'(i), DATA_W'(16'h5000 + i));
    tick();
    tick();
    input_req_valid = '0;
    tick();

    // Write to every address, including r0.
    for (int a = 0; a < 8; a++) begin
      set_req(a % NUM_REQ, 1'b1, ADDR_W'(a), DATA_W'(16'hC000 + a));
      tick();
      input_req_valid = '0;
    end
    tick();
    check_val("rf_r0", 32'(rf[0]), 32'hC000);
    check_val("rf_r7", 32'(rf[7]), 32'hC007);

`ifdef REGFILE_ARB_HAZARD_EN
    set_req(0, 1'b1, 3'd4, 16'h4444);
    tick();
    input_req_valid = '0;
    input_reg_readA_address = 3'd4;
    input_reg_readB_address = 3'd2;
    tick();
    set_req(0, 1'b1, 3'd4, 16'h4445);
    tick();
    input_req_valid = '0;
    input_reg_readA_address = 3'd1;
    tick();
`endif

    // Random traffic obeying the hold-until-granted rule.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == last_grant || !input_req_valid[i]) begin
          set_req(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
        end else if ($urandom_range(0, 9) == 0) begin
          input_req_valid[i] = 1'b0;
        end
      end
      input_hold = ($urandom_range(0, 7) == 0);
`ifdef REGFILE_ARB_HAZARD_EN
      input_reg_readA_address = ADDR_W'($urandom);
      input_reg_readB_address = ADDR_W'($urandom);
`endif
      tick();
    end
    input_req_valid = '0;
    input_hold = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 8x16 register file among several writeback sources: ALU result, memory load data and link/PC value.
- Each requester uses a valid/ready handshake. The block grants one requester per cycle using round-robin, then drives the register-file write port from registers.
- Sits between the multi-cycle control/datapath writeback stage and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width (8 registers).

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset; synchronous, active-low.
- input_hold  input  1  when high, no new grants are issued.
- input_req_valid  input  NUM_REQ  per-requester write request.
- input_req_address  input  NUM_REQ*ADDR_W  packed target addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- input_req_value  input  NUM_REQ*DATA_W  packed write data, same packing as addresses.
- output_req_ready  output  NUM_REQ  one-hot grant, combinational.
- output_reg_write  output  1  register-file write enable, registered.
- output_reg_write_address  output  ADDR_W  registered write address.
- output_reg_write_value  output  DATA_W  registered write data.
- output_grant_id  output  $clog2(NUM_REQ)  index of the requester driving the current write, registered.

Behaviour:
- Reset (RST_N low at a rising edge):
  - output_reg_write=0; address, value and grant_id=0.
  - Round-robin pointer=0.
  - output_req_ready is all zeros while RST_N is low.
- Arbitration, combinational each cycle:
  - If input_hold=0, search upward from the pointer, modulo NUM_REQ, for the first requester with valid=1.
  - Assert ready for that requester only; at most one ready bit is high.
  - If input_hold=1 or no requester is valid, ready=0.
- Handshake: a transfer completes at the edge where valid&ready. A requester must hold valid, address and value stable until that edge. Dropping valid before grant is legal and no write occurs.
- On a transfer at edge E:
  - In the cycle after E, output_reg_write=1 with the captured address, value and id.
  - The register file updates at edge E+1.
  - Pointer becomes (granted index + 1) mod NUM_REQ at edge E.
- With no transfer at an edge: output_reg_write=0 in the following cycle, address and value hold their last values, pointer unchanged.
- Throughput: one write per cycle sustained. Back-to-back grants are allowed to different requesters or to the same requester.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,... and no requester waits more than NUM_REQ-1 grants.
- Same-address writes from two requesters are serialized in grant order; the later grant's value persists. No merging.
- All addresses 0..7 are writable; there is no hardwired zero register.
- input_hold asserted: the pending registered write, if any, still completes, and the pointer is frozen.
- Reset mid-operation: the in-flight registered write is dropped (output_reg_write=0 next cycle) and requesters must re-present.

Optional Feature:
- Macro: REGFILE_ARB_HAZARD_EN.
- Defined:
  - Adds inputs input_reg_readA_address[ADDR_W] and input_reg_readB_address[ADDR_W], and output output_raw_hazard[1] (combinational).
  - output_raw_hazard=1 when output_reg_write=1 and output_reg_write_address equals either read address. This covers the case where the register file's registered read captures stale data on the same edge, so the controller re-issues the read.
- Undefined: these ports do not exist and there is no hazard logic.

Decomposition:
- Package regfile_arb_pkg holds:
  - REG_ADDR_W=3 and REG_DATA_W=16.
  - Requester IDs: REQ_ALU=0, REQ_MEM=1, REQ_LINK=2.
  - Default NUM_REQ=3.
- One sub-module, rr_arbiter: parameterized NUM_REQ; inputs valid, hold and advance; outputs one-hot grant and encoded index. The pointer register lives inside rr_arbiter.
- The top level holds the write-port registers, the packing/unpacking and the optional hazard compare.

Test Plan:
- Reset:
  - Stimulus: hold RST_N=0 for 2 cycles with all valid=1.
  - Required: ready=000 and output_reg_write=0. After release, the first grant goes to requester 0.
- Single write:
  - Stimulus: req1 valid, address 5, value 16'hBEEF.
  - Required: ready[1] same cycle; next cycle write=1, address=5, value=BEEF, grant_id=1.
- Round-robin:
  - Stimulus: all three requesters valid continuously for 6 cycles.
  - Required: grant_id sequence 0,1,2,0,1,2 and a write every cycle.
- Collision:
  - Stimulus: req0 (address 3, 16'h1111) and req2 (address 3, 16'h2222) with pointer=2.
  - Required: req2 is written first, then req0. The register file ends with r3=16'h1111.
- Hold and mid-op reset:
  - Stimulus: assert input_hold with req0 valid, then drop hold; in a separate run, pull RST_N low the cycle after a grant.
  - Required: no ready while held, and the grant follows on release. Under reset, output_reg_write=0 and the pointer returns to 0.
- Hazard (macro defined):
  - Stimulus: write to address 4 is in flight while readA=4 and readB=2.
  - Required: output_raw_hazard=1. With readA=1, the output is 0.
